// File: rtl/reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w
//
// Parametrised CPU register file with two combinational read ports, one
// write port and a per-register busy scoreboard. The decode/control FSM
// reads operands on ports A/B and reserves destination registers with
// rsv_en. The writeback path stores results with wr_en, which also
// releases the reservation.
//
// Parameters
//   DATA_W    width of each register in bits
//   NUM_REGS  number of architectural registers (2..64, any value)
//   ADDR_W    derived address width, $clog2(NUM_REGS); not overridable
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high; clears registers and scoreboard
//   rd_addr_a  read port A select      rd_data_a / rd_busy_a  port A result
//   rd_addr_b  read port B select      rd_data_b / rd_busy_b  port B result
//   wr_en      write strobe; stores wr_data and clears busy of wr_addr
//   wr_addr    write select
//   wr_data    write data
//   rsv_en     reserve strobe; sets busy of rsv_addr
//   rsv_addr   register to reserve
//   busy_vec   registered busy scoreboard, bit i belongs to register i
//
// Optional build macro
//   RF_BYPASS_EN  when defined, a write in flight is forwarded to any read
//                 port selecting the same register in the same cycle
//                 (suppressed while reset is high). When undefined, reads
//                 always return stored state.
//
// Addresses >= NUM_REGS (only reachable when NUM_REGS is not a power of
// two) read as data 0 / busy 0, and writes or reservations to them are
// dropped.
// ---------------------------------------------------------------------------
module reg_file_2r1w #(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_busy_a,

  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_b,

  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,

  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,

  output logic [NUM_REGS-1:0] busy_vec
);

  // Result of one read port: data plus scoreboard flag.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              busy;
  } rd_result_t;

  logic [DATA_W-1:0] mem [NUM_REGS];

  // True when an address names an existing register. Constant-true (and
  // optimised away) when NUM_REGS is a power of two.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < NUM_REGS;
  endfunction

  logic wr_hit;
  logic rsv_hit;

  assign wr_hit  = wr_en  && in_range(wr_addr);
  assign rsv_hit = rsv_en && in_range(rsv_addr);

  // -------------------------------------------------------------------------
  // Storage and scoreboard
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data array is deliberately reset (not left to power-up
      // contents) so that no register can ever read back X after reset.
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
      busy_vec <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; with several targets
      // possibly hitting the same busy bit, the last scheduled update wins.
      if (wr_hit) begin
        mem[wr_addr]      <= wr_data;
        busy_vec[wr_addr] <= 1'b0;
      end
      // Placed after the write release so that a same-register reserve
      // overrides it: a new producer has just been issued.
      if (rsv_hit) begin
        busy_vec[rsv_addr] <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  function automatic rd_result_t read_port(input logic [ADDR_W-1:0] addr);
    rd_result_t res;
    res = '{data: '0, busy: 1'b0};
    if (in_range(addr)) begin
      res.data = mem[addr];
      res.busy = busy_vec[addr];
`ifdef RF_BYPASS_EN
      // Forward the write in flight. The busy flag then reflects what the
      // scoreboard will hold after this edge: released unless re-reserved.
      if (!reset && wr_hit && (wr_addr == addr)) begin
        res.data = wr_data;
        res.busy = rsv_hit && (rsv_addr == addr);
      end
`endif
    end
    return res;
  endfunction

  rd_result_t res_a;
  rd_result_t res_b;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    res_a = '0;
    res_b = '0;
    res_a = read_port(rd_addr_a);
    res_b = read_port(rd_addr_b);
  end

  assign rd_data_a = res_a.data;
  assign rd_busy_a = res_a.busy;
  assign rd_data_b = res_b.data;
  assign rd_busy_b = res_b.busy;

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 3;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (NUM_REGS = 8) ----------------
  logic          reset;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  logic [DW-1:0] rd_data_a, rd_data_b, wr_data;
  logic          rd_busy_a, rd_busy_b, wr_en, rsv_en;
  logic [NR-1:0] busy_vec;

  reg_file_2r1w #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_busy_a(rd_busy_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  // ---------------- non-power-of-two DUT (NUM_REGS = 6) ----------------
  logic          s_reset;
  logic [2:0]    s_rd_addr_a, s_rd_addr_b, s_wr_addr, s_rsv_addr;
  logic [DW-1:0] s_rd_data_a, s_rd_data_b, s_wr_data;
  logic          s_rd_busy_a, s_rd_busy_b, s_wr_en, s_rsv_en;
  logic [5:0]    s_busy_vec;

  reg_file_2r1w #(.DATA_W(DW), .NUM_REGS(6)) dut6 (
    .clk(clk), .reset(s_reset),
    .rd_addr_a(s_rd_addr_a), .rd_data_a(s_rd_data_a), .rd_busy_a(s_rd_busy_a),
    .rd_addr_b(s_rd_addr_b), .rd_data_b(s_rd_data_b), .rd_busy_b(s_rd_busy_b),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr), .busy_vec(s_busy_vec)
  );

  // ---------------- reference model (8-register DUT) ----------------
  logic [DW-1:0] m_mem [NR];
  logic [NR-1:0] m_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural effect of one rising edge with the current inputs.
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
      m_busy = '0;
    end else begin
      if (wr_en) m_mem[wr_addr] = wr_data;
      for (int i = 0; i < NR; i++) begin
        if (rsv_en && rsv_addr == AW'(i))      m_busy[i] = 1'b1;
        else if (wr_en && wr_addr == AW'(i))   m_busy[i] = 1'b0;
      end
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = m_mem[a];
`ifdef RF_BYPASS_EN
    if (!reset && wr_en && wr_addr == a) r = wr_data;
`endif
    return r;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    logic r;
    r = m_busy[a];
`ifdef RF_BYPASS_EN
    if (!reset && wr_en && wr_addr == a) r = rsv_en && (rsv_addr == a);
`endif
    return r;
  endfunction

  // Advance one clock: update model with sampled inputs, then settle.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    reset = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [DW-1:0] exp_da;
    logic [DW-1:0] exp_db;
    logic          exp_ba;
    logic          exp_bb;
    logic [NR-1:0] exp_vec;
  } vec_t;

  vec_t vt [14];

  initial begin
    //           rst we wa  wd        re ra  a  b   da        db        ba bb vec
    vt[0]  = '{1'b1,1'b0,3'd0,16'h0000,1'b0,3'd0,3'd0,3'd0,16'h0000,16'h0000,1'b0,1'b0,8'h00};
    vt[1]  = '{1'b0,1'b1,3'd3,16'hBEEF,1'b0,3'd0,3'd3,3'd5,16'hBEEF,16'h0000,1'b0,1'b0,8'h00};
    vt[2]  = '{1'b0,1'b1,3'd5,16'h1234,1'b0,3'd0,3'd3,3'd5,16'hBEEF,16'h1234,1'b0,1'b0,8'h00};
    vt[3]  = '{1'b0,1'b0,3'd0,16'h0000,1'b0,3'd0,3'd5,3'd5,16'h1234,16'h1234,1'b0,1'b0,8'h00};
    vt[4]  = '{1'b0,1'b0,3'd0,16'h0000,1'b1,3'd2,3'd2,3'd3,16'h0000,16'hBEEF,1'b1,1'b0,8'h04};
    vt[5]  = '{1'b0,1'b1,3'd2,16'h00AA,1'b0,3'd0,3'd2,3'd2,16'h00AA,16'h00AA,1'b0,1'b0,8'h00};
    vt[6]  = '{1'b0,1'b1,3'd6,16'h5555,1'b1,3'd6,3'd6,3'd2,16'h5555,16'h00AA,1'b1,1'b0,8'h40};
    vt[7]  = '{1'b0,1'b0,3'd0,16'h0000,1'b1,3'd6,3'd6,3'd6,16'h5555,16'h5555,1'b1,1'b1,8'h40};
    vt[8]  = '{1'b1,1'b1,3'd1,16'hFFFF,1'b0,3'd0,3'd1,3'd6,16'h0000,16'h0000,1'b0,1'b0,8'h00};
    vt[9]  = '{1'b0,1'b1,3'd7,16'h0F0F,1'b1,3'd0,3'd7,3'd0,16'h0F0F,16'h0000,1'b0,1'b1,8'h01};
    vt[10] = '{1'b0,1'b1,3'd0,16'h0001,1'b0,3'd0,3'd0,3'd7,16'h0001,16'h0F0F,1'b0,1'b0,8'h00};
    vt[11] = '{1'b0,1'b1,3'd4,16'h4444,1'b0,3'd0,3'd4,3'd4,16'h4444,16'h4444,1'b0,1'b0,8'h00};
    vt[12] = '{1'b0,1'b0,3'd0,16'h0000,1'b1,3'd3,3'd3,3'd4,16'h0000,16'h4444,1'b1,1'b0,8'h08};
    vt[13] = '{1'b1,1'b0,3'd0,16'h0000,1'b1,3'd5,3'd5,3'd3,16'h0000,16'h0000,1'b0,1'b0,8'h00};
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;
    wr_addr = '0; wr_data = '0; rsv_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    s_reset = 1'b1; s_wr_en = 1'b0; s_rsv_en = 1'b0;
    s_wr_addr = '0; s_wr_data = '0; s_rsv_addr = '0; s_rd_addr_a = '0; s_rd_addr_b = '0;

    // Reset, then sweep every register on both ports.
    tick();
    clear_strobes();
    s_reset = 1'b0;
    check("reset_busy_vec", busy_vec, 8'h00);
    for (int i = 0; i < NR; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(NR - 1 - i);
      #1;
      check("reset_data_a", rd_data_a, 16'h0000);
      check("reset_data_b", rd_data_b, 16'h0000);
      check("reset_busy_a", rd_busy_a, 1'b0);
      check("reset_busy_b", rd_busy_b, 1'b0);
    end

    // Table vectors: apply for one edge, then check the settled state.
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      reset = vt[v].rst; wr_en = vt[v].we; wr_addr = vt[v].wa; wr_data = vt[v].wd;
      rsv_en = vt[v].re; rsv_addr = vt[v].ra;
      rd_addr_a = vt[v].a; rd_addr_b = vt[v].b;
      tick();
      clear_strobes();
      @(negedge clk);
      check($sformatf("vec%0d_data_a", v), rd_data_a, vt[v].exp_da);
      check($sformatf("vec%0d_data_b", v), rd_data_b, vt[v].exp_db);
      check($sformatf("vec%0d_busy_a", v), rd_busy_a, vt[v].exp_ba);
      check($sformatf("vec%0d_busy_b", v), rd_busy_b, vt[v].exp_bb);
      check($sformatf("vec%0d_busy_vec", v), busy_vec, vt[v].exp_vec);
    end

    // Same-cycle write/read of R4 (R4 = 0, nothing busy here).
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hCAFE; rd_addr_a = 3'd4; rd_addr_b = 3'd4;
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_same_cycle", rd_data_a, 16'hCAFE);
`else
    check("bypass_same_cycle", rd_data_a, 16'h0000);
`endif
    check("bypass_busy_a", rd_busy_a, 1'b0);
    tick();
    clear_strobes();
    check("bypass_next_cycle", rd_data_a, 16'hCAFE);

    // Write plus reserve of the same register, observed before the edge.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h1111; rsv_en = 1'b1; rsv_addr = 3'd4;
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_rsv_data", rd_data_b, 16'h1111);
    check("bypass_rsv_busy", rd_busy_b, 1'b1);
`else
    check("bypass_rsv_data", rd_data_b, 16'hCAFE);
    check("bypass_rsv_busy", rd_busy_b, 1'b0);
`endif
    tick();
    clear_strobes();
    check("after_rsv_data", rd_data_b, 16'h1111);
    check("after_rsv_busy", rd_busy_b, 1'b1);

    // Forwarding must not apply while reset is high.
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h2222;
    #1;
    check("reset_no_bypass_data", rd_data_a, 16'h1111);
    check("reset_no_bypass_busy", rd_busy_a, 1'b1);
    tick();
    clear_strobes();
    check("reset_wins_data", rd_data_a, 16'h0000);
    check("reset_wins_vec", busy_vec, 8'h00);

    // Non-power-of-two instance: out-of-range write/reserve are dropped.
    @(negedge clk);
    s_wr_en = 1'b1; s_wr_addr = 3'd7; s_wr_data = 16'h7777;
    s_rsv_en = 1'b1; s_rsv_addr = 3'd6; s_rd_addr_a = 3'd7; s_rd_addr_b = 3'd6;
    #1;
    check("oor_pre_data", s_rd_data_a, 16'h0000);
    check("oor_pre_busy", s_rd_busy_a, 1'b0);
    tick();
    s_wr_en = 1'b0; s_rsv_en = 1'b0;
    check("oor_busy_vec", s_busy_vec, 6'h00);
    check("oor_data_a", s_rd_data_a, 16'h0000);
    check("oor_busy_a", s_rd_busy_a, 1'b0);
    check("oor_data_b", s_rd_data_b, 16'h0000);
    @(negedge clk);
    s_wr_en = 1'b1; s_wr_addr = 3'd5; s_wr_data = 16'h5A5A;
    s_rsv_en = 1'b1; s_rsv_addr = 3'd5; s_rd_addr_a = 3'd5; s_rd_addr_b = 3'd7;
    tick();
    s_wr_en = 1'b0; s_rsv_en = 1'b0;
    check("top_reg_data", s_rd_data_a, 16'h5A5A);
    check("top_reg_busy", s_rd_busy_a, 1'b1);
    check("top_reg_vec", s_busy_vec, 6'h20);
    check("oor_still_zero", s_rd_data_b, 16'h0000);

    // Randomised traffic against the model, checked before every edge.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      reset     = ($urandom_range(39) == 0);
      wr_en     = $urandom_range(1);
      wr_addr   = AW'($urandom_range(NR - 1));
      wr_data   = DW'($urandom);
      rsv_en    = ($urandom_range(2) == 0);
      rsv_addr  = AW'($urandom_range(NR - 1));
      rd_addr_a = ($urandom_range(3) == 0) ? wr_addr : AW'($urandom_range(NR - 1));
      rd_addr_b = ($urandom_range(3) == 0) ? rsv_addr : AW'($urandom_range(NR - 1));
      #1;
      check("rand_data_a", rd_data_a, exp_data(rd_addr_a));
      check("rand_data_b", rd_data_b, exp_data(rd_addr_b));
      check("rand_busy_a", rd_busy_a, exp_busy(rd_addr_a));
      check("rand_busy_b", rd_busy_b, exp_busy(rd_addr_b));
      check("rand_busy_vec", busy_vec, m_busy);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
